icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch port and the instruction side of memory control (iREN/iaddr out, iwait/iload in).
- Serves hits combinationally.
- On a miss, runs a one-word refill through memory control and stalls fetch until the frame is written.
- Provides a flush for self-modifying code / halt, and saturating hit/miss counters for performance reporting.

Parameters:
- SETS, 16, number of one-word frames; power of two, 2..256; IDX = log2(SETS), TAGW = 30 - IDX.
- CNTW, 16, width of each saturating hit/miss counter.

Ports:
- CLK  input  1  rising-edge clock.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  fetch served this cycle.
- imemload  output  32  instruction word, valid when ihit=1.
- flush  input  1  invalidate all frames (synchronous).
- iREN  output  1  read request to memory control.
- iaddr  output  32  word-aligned refill address to memory control.
- iwait  input  1  memory control stall; 0 = iload valid this cycle.
- iload  input  32  refill data from memory control.
- hitcnt  output  CNTW  saturating hit count.
- misscnt  output  CNTW  saturating miss count.

Behaviour:
- Address split: tag = imemaddr[31:IDX+2], idx = imemaddr[IDX+1:2].
- Frame state: valid[SETS], tag[SETS][TAGW], data[SETS][32]. Reset clears all valid bits. Tags and data need no reset.
- Hit (combinational): ihit = imemREN & state==IDLE & valid[idx] & tag[idx]==tag.
  - When ihit=1, imemload = data[idx]; otherwise imemload = 0.
- FSM states IDLE, FETCH. Reset enters IDLE.
- IDLE:
  - imemREN & !hit & !flush → latch missaddr = {imemaddr[31:2],2'b00}, go FETCH, misscnt+1.
  - A hit increments hitcnt.
- FETCH:
  - iREN=1, iaddr=missaddr, ihit=0.
  - When iwait=0, at that edge: valid[missidx]=1, tag[missidx]=misstag, data[missidx]=iload; go IDLE.
  - The refill completes on missaddr even if imemREN drops or imemaddr changes mid-FETCH.
- Outside FETCH: iREN=0, iaddr=0.
- Latency:
  - Hit: 0 cycles.
  - Miss: detect at cycle 0; FETCH from cycle 1; fill at the first edge with iwait=0; ihit=1 the following cycle if the request is unchanged.
  - Minimum miss penalty is 2 cycles.
- Flush:
  - Clears all valid bits at the next edge and forces IDLE; it has priority over a fill and over a new miss.
  - An in-progress refill is abandoned, iREN drops the next cycle, and no frame is written.
  - ihit=0 during any cycle with flush=1.
  - Counters are not affected by flush.
- Simultaneous fill and new request: the cycle after the fill is IDLE, and the hit check uses the updated frame.
- Conflict eviction: a miss to an index holding a valid frame overwrites that frame unconditionally. No write-back is needed (read-only cache).
- Counters saturate at 2^CNTW-1 and are never cleared except by reset.
- Reset mid-FETCH: asynchronous return to IDLE; iREN=0, ihit=0, imemload=0, counters=0, all valid=0 immediately.
- Output reset values: ihit 0, imemload 0, iREN 0, iaddr 0, hitcnt 0, misscnt 0.

Test Plan:
- Cold miss:
  - Stimulus: imemREN=1, imemaddr=0x0000_0040; memory model holds iwait=1 for 3 cycles then iwait=0, iload=0x2008_0005.
  - Required: iREN=1 and iaddr=0x40 from cycle 1; ihit=1 with imemload=0x2008_0005 on the cycle after the fill; misscnt=1, hitcnt=1.
- Repeat hits:
  - Stimulus: after the fill above, fetch 0x40 for 5 consecutive cycles.
  - Required: ihit=1 every cycle, iREN=0, hitcnt=6.
- Conflict eviction:
  - Stimulus: with SETS=16, fetch 0x40 (filled), then 0x440 (same idx 0, different tag), then 0x40 again.
  - Required: three misses in total; frame 0 ends holding the 0x40 data.
- Flush mid-FETCH:
  - Stimulus: miss on 0x80, assert flush while iwait=1.
  - Required: iREN=0 the next cycle; valid all 0; a later fetch of 0x40 misses.
- Async reset in FETCH:
  - Stimulus: drop nRST between clock edges during a refill.
  - Required: iREN, ihit, hitcnt and misscnt go to 0 immediately without a clock.
- Saturation:
  - Stimulus: CNTW=4, 20 hits.
  - Required: hitcnt holds 15.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-control-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the datapath/memory environment uses master.
interface icache_direct_if #(
    parameter int unsigned CNTW = 16
);
    logic            imemREN;
    logic [31:0]     imemaddr;
    logic            ihit;
    logic [31:0]     imemload;
    logic            flush;
    logic            iREN;
    logic [31:0]     iaddr;
    logic            iwait;
    logic [31:0]     iload;
    logic [CNTW-1:0] hitcnt;
    logic [CNTW-1:0] misscnt;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hitcnt, misscnt
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hitcnt, misscnt
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hits, one-word refill on miss,
// synchronous flush, and saturating hit/miss counters.
module icache_direct #(
    parameter int unsigned SETS = 16,
    parameter int unsigned CNTW = 16
) (
    input  logic           CLK,
    input  logic           nRST,
    icache_direct_if.slave bus
);
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = 30 - IDX;

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e          state_q, state_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [29:0]     missaddr_q, missaddr_d;
    logic            iren_q, iren_d;
    logic [31:0]     iaddr_q, iaddr_d;
    logic [CNTW-1:0] hitcnt_q, hitcnt_d;
    logic [CNTW-1:0] misscnt_q, misscnt_d;

    logic [TAGW-1:0] tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];

    logic [TAGW-1:0] req_tag;
    logic [IDX-1:0]  req_idx;
    logic [TAGW-1:0] miss_tag;
    logic [IDX-1:0]  miss_idx;
    logic            hit;
    logic            fill;
    logic            unused_addr_bits;

    assign req_tag          = bus.imemaddr[31:IDX+2];
    assign req_idx          = bus.imemaddr[IDX+1:2];
    assign miss_tag         = missaddr_q[29:IDX];
    assign miss_idx         = missaddr_q[IDX-1:0];
    assign unused_addr_bits = ^bus.imemaddr[1:0];

    // A flush cycle never reports a hit, so flush also blocks the hit counter.
    assign hit  = bus.imemREN & ~bus.flush & (state_q == IDLE)
                & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);
    assign fill = (state_q == FETCH) & ~bus.flush & ~bus.iwait;

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_mem[req_idx] : '0;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iaddr_q;
    assign bus.hitcnt   = hitcnt_q;
    assign bus.misscnt  = misscnt_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        missaddr_d = missaddr_q;
        iren_d     = iren_q;
        iaddr_d    = iaddr_q;
        hitcnt_d   = hitcnt_q;
        misscnt_d  = misscnt_q;

        if (hit && hitcnt_q != '1) begin
            hitcnt_d = hitcnt_q + 1'b1;
        end

        if (bus.flush) begin
            valid_d = '0;
            state_d = IDLE;
            iren_d  = 1'b0;
            iaddr_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.imemREN && !hit) begin
                        missaddr_d = bus.imemaddr[31:2];
                        state_d    = FETCH;
                        iren_d     = 1'b1;
                        iaddr_d    = {bus.imemaddr[31:2], 2'b00};
                        if (misscnt_q != '1) begin
                            misscnt_d = misscnt_q + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (!bus.iwait) begin
                        valid_d[miss_idx] = 1'b1;
                        state_d           = IDLE;
                        iren_d            = 1'b0;
                        iaddr_d           = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            missaddr_q <= '0;
            iren_q     <= 1'b0;
            iaddr_q    <= '0;
            hitcnt_q   <= '0;
            misscnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            missaddr_q <= missaddr_d;
            iren_q     <= iren_d;
            iaddr_q    <= iaddr_d;
            hitcnt_q   <= hitcnt_d;
            misscnt_q  <= misscnt_d;
        end
    end

    // Tag and data storage need no reset; the valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.iload;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: memory-control model with programmable
// latency, expected fetch words queued per request and compared when ihit appears.
module tb_icache_direct;
    localparam int unsigned SETS = 16;
    localparam int unsigned CNTW = 4;
    localparam int unsigned CMAX = (1 << CNTW) - 1;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    icache_direct_if #(.CNTW(CNTW)) bus ();

    icache_direct #(.SETS(SETS), .CNTW(CNTW)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] exp_q[$];
    int unsigned exp_hits;
    int unsigned exp_miss;
    int unsigned mem_lat;
    int unsigned mem_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0005 ^ ((a - 32'h40) << 4);
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v >= CMAX) ? v : v + 1;
    endfunction

    // Memory control: holds iwait for mem_lat cycles of an iREN request, then returns data.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)                    mem_cnt <= 0;
        else if (bus.iREN && bus.iwait) mem_cnt <= mem_cnt + 1;
        else                          mem_cnt <= 0;
    end
    assign bus.iwait = !(bus.iREN && (mem_cnt >= mem_lat));
    assign bus.iload = bus.iwait ? 32'h0 : mem_word(bus.iaddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hitcnt"}, 32'(bus.hitcnt), exp_hits);
        check({tag, "_misscnt"}, 32'(bus.misscnt), exp_miss);
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.ihit) begin
                if (exp_q.size() == 0) check("spurious_ihit", 32'(bus.ihit), 32'h0);
                else                   check("imemload", bus.imemload, exp_q.pop_front());
            end else begin
                check("imemload_zero", bus.imemload, 32'h0);
            end
        end
    end

    // Holds the request until ihit; called just after a rising edge.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input string tag);
        int unsigned cyc = 0;
        int unsigned want;
        bit          got_hit = 1'b0;
        want = exp_hit ? 0 : mem_lat + 2;
        exp_q.push_back(mem_word(a));
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.ihit) begin
                got_hit = 1'b1;
                check({tag, "_iren_on_hit"}, 32'(bus.iREN), 32'h0);
                break;
            end
            if (cyc > 0) begin
                check({tag, "_iren"}, 32'(bus.iREN), 32'h1);
                check({tag, "_iaddr"}, bus.iaddr, {a[31:2], 2'b00});
            end
            cyc++;
            @(posedge CLK); #1;
        end
        check({tag, "_latency"}, cyc, want);
        if (!got_hit) void'(exp_q.pop_back());
        @(posedge CLK); #1;
        exp_hits = sat(exp_hits);
        if (!exp_hit) exp_miss = sat(exp_miss);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.flush    = 1'b0;
        mem_lat      = 3;
        exp_hits     = 0;
        exp_miss     = 0;
        nRST         = 1'b1;
        #2 nRST = 1'b0;
        #1;
        check("rst_ihit", 32'(bus.ihit), 32'h0);
        check("rst_imemload", bus.imemload, 32'h0);
        check("rst_iren", 32'(bus.iREN), 32'h0);
        check("rst_iaddr", bus.iaddr, 32'h0);
        check_counts("rst");
        repeat (2) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        fetch(32'h40, 1'b0, "cold");
        check_counts("cold");
        repeat (5) fetch(32'h40, 1'b1, "rehit");
        check_counts("rehit");

        mem_lat = 0;
        fetch(32'hC0, 1'b0, "minpen");

        mem_lat = 1;
        fetch(32'h440, 1'b0, "evict");
        fetch(32'h40, 1'b0, "refill");
        fetch(32'h40, 1'b1, "evicted_hit");
        check_counts("evict");

        // Flush with a would-be hit pending in IDLE
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h40;
        bus.flush    = 1'b1;
        @(negedge CLK);
        check("flush_no_hit", 32'(bus.ihit), 32'h0);

        // Flush during a refill
        mem_lat = 10;
        @(posedge CLK); #1;
        bus.flush    = 1'b0;
        bus.imemaddr = 32'h80;
        @(posedge CLK); #1;
        exp_miss = sat(exp_miss);
        @(negedge CLK);
        check("flush_fetch_iren", 32'(bus.iREN), 32'h1);
        @(posedge CLK); #1;
        bus.flush = 1'b1;
        @(posedge CLK); #1;
        bus.flush   = 1'b0;
        bus.imemREN = 1'b0;
        @(negedge CLK);
        check("flush_iren_drop", 32'(bus.iREN), 32'h0);
        check("flush_iaddr_zero", bus.iaddr, 32'h0);
        check_counts("flush");
        @(posedge CLK); #1;
        mem_lat = 1;
        fetch(32'h40, 1'b0, "post_flush");

        // Request moves away and drops mid-refill; refill still lands on the original line
        mem_lat      = 2;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h200;
        @(posedge CLK); #1;
        exp_miss = sat(exp_miss);
        bus.imemaddr = 32'h300;
        @(negedge CLK);
        check("addr_change_iaddr", bus.iaddr, 32'h200);
        @(posedge CLK); #1;
        bus.imemREN = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        fetch(32'h200, 1'b1, "addr_change");
        check_counts("addr_change");

        // Asynchronous reset while a refill is outstanding
        mem_lat      = 10;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h100;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("areset_pre_iren", 32'(bus.iREN), 32'h1);
        #2 nRST = 1'b0;
        #1;
        exp_hits = 0;
        exp_miss = 0;
        check("areset_iren", 32'(bus.iREN), 32'h0);
        check("areset_iaddr", bus.iaddr, 32'h0);
        check("areset_ihit", 32'(bus.ihit), 32'h0);
        check("areset_imemload", bus.imemload, 32'h0);
        check_counts("areset");
        bus.imemREN = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        mem_lat = 1;
        fetch(32'h40, 1'b0, "sat_fill");
        repeat (20) fetch(32'h40, 1'b1, "sat");
        bus.imemREN = 1'b0;
        check("sat_hitcnt", 32'(bus.hitcnt), 32'd15);
        check_counts("sat");
        check("queue_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
